leds_bank: RTL and testbench
============================

Name: leds_bank

Overview:
- Parametrised memory-mapped LED output controller; next generation of the board LED output port.
- Sits on the MemOrIO bus; the CPU writes 16-bit halfwords selected by `ledaddr`.
- Adds over the fixed 24-bit port:
  - generic LED count;
  - per-LED blink mask with a programmable blink period;
  - global enable and polarity control;
  - registered, glitch-free outputs.

Parameters:
- NUM_LEDS, 24, number of LED outputs; legal range 1..64.
- ADDR_W, 5, width of `ledaddr` (byte address); halfword index = `ledaddr[ADDR_W-1:1]`.
- PRESCALE, 50000, `led_clk` cycles per blink tick; must be >= 1.

Ports:
- led_clk  input  1  block clock.
- ledrst  input  1  reset, asynchronous, active-high.
- ledwrite  input  1  write enable, active-high.
- ledcs  input  1  chip select; block is addressed when 1.
- ledaddr  input  ADDR_W  byte address of target halfword; bit 0 ignored.
- ledwdata  input  16  write data.
- ledout  output  NUM_LEDS  registered drive to board LEDs.

Behaviour:
- Derived: NH = ceil(NUM_LEDS/16). Halfword index k = `ledaddr[ADDR_W-1:1]`.
- Register map, written when ledcs && ledwrite on the rising edge of `led_clk`:
  - k=0..NH-1: DATA[16k+15:16k].
  - k=4..4+NH-1: MASK[16(k-4)+15:16(k-4)].
  - k=8: PERIOD[15:0], in ticks.
  - k=9: CTRL; bit0 = EN, bit1 = INV; other bits ignored.
  - All other k: write ignored, no state change.
- Halfword bits at positions >= NUM_LEDS are discarded.
- Only the addressed halfword changes; all other bits hold.
- Reset (async, immediate):
  - DATA=0, MASK=0, PERIOD=0, EN=1, INV=0;
  - prescaler=0, tick count=0, PHASE=1;
  - ledout=0.
- Prescaler:
  - counts 0..PRESCALE-1 every cycle, then wraps to 0;
  - emits a one-cycle TICK when it wraps.
- Blink counter:
  - on TICK, if PERIOD != 0: if tick count == PERIOD-1, then tick count <= 0 and PHASE toggles; else tick count increments.
  - PERIOD == 0: PHASE forced to 1, tick count held at 0 (masked LEDs steady on).
- A write to PERIOD, in the same edge:
  - clears prescaler and tick count;
  - sets PHASE=1.
  - This restarts blinking in a known phase.
- Write to PERIOD coinciding with TICK: the write wins; counters are cleared, no toggle.
- Output, registered every cycle:
  - ledout[i] <= EN ? ((DATA[i] & (~MASK[i] | PHASE)) ^ INV) : INV.
  - Uses post-write register values from the previous edge.
  - A write is therefore visible on ledout one `led_clk` cycle after the write edge.
- With ledcs=0 or ledwrite=0, registers hold. Counters run freely regardless of ledcs.
- Reset asserted mid-blink: everything returns to reset values immediately. Blinking restarts from PHASE=1 after deassertion.

Optional Feature:
- Macro: LEDS_BANK_READBACK_EN.
- Defined:
  - adds input `ledread` (1) and output `ledrdata` (16).
  - When ledcs && ledread, `ledrdata` returns the register at halfword index k combinationally, same map as writes.
  - Unused bits read 0; CTRL returns {14'b0, INV, EN}.
  - Unmapped indices read 16'h0000.
  - When not selected, `ledrdata` = 16'h0000.
- Not defined: no read port exists; the block is write-only.

Test Plan:
- Reset, then write DATA with k=0 16'hA5A5 and k=1 16'h00FF (NUM_LEDS=24) -> ledout = 24'hFFA5A5 one cycle after the second write. Bits [15:8] of the k=1 write are dropped.
- With ledcs=0 and ledwrite=1, write 16'hFFFF at k=0 -> ledout unchanged. Write to k=3 (unmapped) -> no change.
- PRESCALE=2, PERIOD=3, MASK k=4 = 16'h000F, DATA = 24'h00FFFF -> ledout[3:0] toggles between 4'hF and 4'h0 every 6 cycles; ledout[15:4] steady 1.
- Write PERIOD=3 mid-blink while PHASE=0 -> PHASE=1 next cycle; the next toggle occurs 6 cycles after the write.
- CTRL=2'b10 (EN=0, INV=1) -> ledout = 24'hFFFFFF. CTRL=2'b11 with DATA=24'h00FFFF -> ledout = 24'hFF0000.
- Assert ledrst asynchronously between clock edges during blinking -> ledout=0 immediately, without waiting for an edge. After release, with DATA=0, ledout stays 0.

Source files
------------

// File: rtl/leds_bank.sv
// rtl/leds_bank.sv - memory-mapped LED bank with blink mask, period, enable and polarity.
// Optional readback port enabled by defining LEDS_BANK_READBACK_EN.
module leds_bank #(
    parameter int NUM_LEDS = 24,
    parameter int ADDR_W   = 5,
    parameter int PRESCALE = 50000
) (
    input  logic                led_clk,
    input  logic                ledrst,
    input  logic                ledwrite,
    input  logic                ledcs,
    input  logic [ADDR_W-1:0]   ledaddr,
    input  logic [15:0]         ledwdata,
`ifdef LEDS_BANK_READBACK_EN
    input  logic                ledread,
    output logic [15:0]         ledrdata,
`endif
    output logic [NUM_LEDS-1:0] ledout
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [ADDR_W-2:0]   k;
    logic                wr;
    logic                tick;
    logic                unused_addr_lsb;

    logic [NUM_LEDS-1:0] data_q, data_d;
    logic [NUM_LEDS-1:0] mask_q, mask_d;
    logic [15:0]         period_q, period_d;
    logic                en_q, en_d;
    logic                inv_q, inv_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [15:0]         tcnt_q, tcnt_d;
    logic                phase_q, phase_d;
    logic [NUM_LEDS-1:0] ledout_q, ledout_d;

    assign k               = ledaddr[ADDR_W-1:1];
    assign unused_addr_lsb = ledaddr[0];
    assign wr              = ledcs & ledwrite;
    assign tick            = (presc_q == PW'(PRESCALE - 1));

    // Per-bit write select: bit i lives in halfword i/16, so bits past NUM_LEDS simply never exist.
    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        en_d     = en_q;
        inv_d    = inv_q;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (wr && int'(k) == i / 16)     data_d[i] = ledwdata[i % 16];
            if (wr && int'(k) == i / 16 + 4) mask_d[i] = ledwdata[i % 16];
        end
        if (wr && int'(k) == 8) period_d = ledwdata;
        if (wr && int'(k) == 9) begin
            en_d  = ledwdata[0];
            inv_d = ledwdata[1];
        end
    end

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        tcnt_d  = tcnt_q;
        phase_d = phase_q;
        if (period_q == 16'd0) begin
            tcnt_d  = 16'd0;
            phase_d = 1'b1;
        end else if (tick) begin
            if (tcnt_q == period_q - 16'd1) begin
                tcnt_d  = 16'd0;
                phase_d = ~phase_q;
            end else begin
                tcnt_d = tcnt_q + 16'd1;
            end
        end
        // A period write restarts blinking in the on phase and overrides a coincident tick.
        if (wr && int'(k) == 8) begin
            presc_d = '0;
            tcnt_d  = 16'd0;
            phase_d = 1'b1;
        end
    end

    assign ledout_d = en_q ? ((data_q & (~mask_q | {NUM_LEDS{phase_q}})) ^ {NUM_LEDS{inv_q}})
                           : {NUM_LEDS{inv_q}};

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            data_q   <= '0;
            mask_q   <= '0;
            period_q <= 16'd0;
            en_q     <= 1'b1;
            inv_q    <= 1'b0;
            presc_q  <= '0;
            tcnt_q   <= 16'd0;
            phase_q  <= 1'b1;
            ledout_q <= '0;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            en_q     <= en_d;
            inv_q    <= inv_d;
            presc_q  <= presc_d;
            tcnt_q   <= tcnt_d;
            phase_q  <= phase_d;
            ledout_q <= ledout_d;
        end
    end

    assign ledout = ledout_q;

`ifdef LEDS_BANK_READBACK_EN
    always_comb begin
        ledrdata = 16'h0000;
        if (ledcs && ledread) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (int'(k) == i / 16)     ledrdata[i % 16] = data_q[i];
                if (int'(k) == i / 16 + 4) ledrdata[i % 16] = mask_q[i];
            end
            if (int'(k) == 8) ledrdata = period_q;
            if (int'(k) == 9) ledrdata = {14'b0, inv_q, en_q};
        end
    end
`endif

endmodule

// File: tb/tb_leds_bank.sv
// tb/tb_leds_bank.sv - self-checking bench for leds_bank (NUM_LEDS=24, PRESCALE=2).
module tb_leds_bank;
    logic        led_clk = 1'b0;
    logic        ledrst;
    logic        ledwrite;
    logic        ledcs;
    logic [4:0]  ledaddr;
    logic [15:0] ledwdata;
    logic [23:0] ledout;
`ifdef LEDS_BANK_READBACK_EN
    logic        ledread;
    logic [15:0] ledrdata;
`endif

    leds_bank #(.NUM_LEDS(24), .ADDR_W(5), .PRESCALE(2)) dut (
        .led_clk  (led_clk),
        .ledrst   (ledrst),
        .ledwrite (ledwrite),
        .ledcs    (ledcs),
        .ledaddr  (ledaddr),
        .ledwdata (ledwdata),
`ifdef LEDS_BANK_READBACK_EN
        .ledread  (ledread),
        .ledrdata (ledrdata),
`endif
        .ledout   (ledout)
    );

    always #5 led_clk = ~led_clk;

    typedef struct {
        logic        cs;
        logic        we;
        logic [3:0]  k;
        logic [15:0] wd;
        logic [23:0] exp;
    } vec_t;

    vec_t        vecs[13];
    logic [23:0] sb[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        logic [23:0] exp;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 24'h0, 24'h1);
        end else begin
            exp = sb.pop_front();
            check(name, ledout, exp);
        end
    endtask

    task automatic drive(input logic cs, input logic we, input logic [3:0] k, input logic [15:0] wd);
        logic lsb;
        lsb      = 1'($urandom_range(0, 1));
        ledcs    = cs;
        ledwrite = we;
        ledaddr  = {k, lsb};
        ledwdata = wd;
    endtask

    task automatic idle();
        ledcs    = 1'b0;
        ledwrite = 1'b0;
    endtask

    // Period write, then n samples; phase lasts 3 ticks * 2 cycles = 6 cycles.
    task automatic blink(input int n, input string tag);
        drive(1'b1, 1'b1, 4'd8, 16'd3);
        for (int i = 1; i <= n; i++)
            sb.push_back(24'h00FFF0 | ((((i - 1) / 6) % 2 == 0) ? 24'hF : 24'h0));
        @(negedge led_clk);
        idle();
        for (int i = 1; i <= n; i++) begin
            @(negedge led_clk);
            pop_check($sformatf("%s_c%0d", tag, i));
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 4'd0,  16'hA5A5, 24'h00A5A5};
        vecs[1]  = '{1'b1, 1'b1, 4'd1,  16'h12FF, 24'hFFA5A5};
        vecs[2]  = '{1'b0, 1'b1, 4'd0,  16'hFFFF, 24'hFFA5A5};
        vecs[3]  = '{1'b1, 1'b0, 4'd0,  16'hFFFF, 24'hFFA5A5};
        vecs[4]  = '{1'b1, 1'b1, 4'd3,  16'hFFFF, 24'hFFA5A5};
        vecs[5]  = '{1'b1, 1'b1, 4'd15, 16'hFFFF, 24'hFFA5A5};
        vecs[6]  = '{1'b1, 1'b1, 4'd0,  16'hFFFF, 24'hFFFFFF};
        vecs[7]  = '{1'b1, 1'b1, 4'd1,  16'h0000, 24'h00FFFF};
        vecs[8]  = '{1'b1, 1'b1, 4'd9,  16'h0002, 24'hFFFFFF};
        vecs[9]  = '{1'b1, 1'b1, 4'd9,  16'h0003, 24'hFF0000};
        vecs[10] = '{1'b1, 1'b1, 4'd9,  16'h0000, 24'h000000};
        vecs[11] = '{1'b1, 1'b1, 4'd9,  16'hFFF1, 24'h00FFFF};
        vecs[12] = '{1'b1, 1'b1, 4'd4,  16'h000F, 24'h00FFFF};

        ledrst   = 1'b1;
        ledaddr  = 5'd0;
        ledwdata = 16'h0;
        idle();
`ifdef LEDS_BANK_READBACK_EN
        ledread = 1'b0;
`endif
        repeat (2) @(negedge led_clk);
        check("reset_held", ledout, 24'h0);
        ledrst = 1'b0;
        @(negedge led_clk);
        check("reset_released", ledout, 24'h0);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].cs, vecs[i].we, vecs[i].k, vecs[i].wd);
            sb.push_back(vecs[i].exp);
            @(negedge led_clk);
            idle();
            @(negedge led_clk);
            pop_check($sformatf("vec%0d", i));
        end

`ifdef LEDS_BANK_READBACK_EN
        ledread = 1'b1;
        drive(1'b1, 1'b0, 4'd0, 16'h0);
        #1 check("rd_data0", {8'h0, ledrdata}, 24'h00FFFF);
        drive(1'b1, 1'b0, 4'd4, 16'h0);
        #1 check("rd_mask0", {8'h0, ledrdata}, 24'h00000F);
        drive(1'b1, 1'b0, 4'd9, 16'h0);
        #1 check("rd_ctrl", {8'h0, ledrdata}, 24'h000001);
        drive(1'b1, 1'b0, 4'd3, 16'h0);
        #1 check("rd_unmapped", {8'h0, ledrdata}, 24'h000000);
        ledread = 1'b0;
        idle();
        @(negedge led_clk);
`endif

        blink(10, "blink");
        blink(14, "restart");

        #2 ledrst = 1'b1;
        #1 check("async_reset", ledout, 24'h0);
        @(negedge led_clk);
        ledrst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(24'h0);
            @(negedge led_clk);
            pop_check($sformatf("post_reset%0d", i));
        end

        drive(1'b1, 1'b1, 4'd0, 16'h000F);
        sb.push_back(24'h00000F);
        @(negedge led_clk);
        idle();
        @(negedge led_clk);
        pop_check("post_reset_write");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
